// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor. An accepted START captures A and B, then
//   one bit-step per clock (LSB first) ripples the borrow through a single
//   flop. After WIDTH steps the result and final borrow are loaded into the
//   output registers and DONE pulses for one cycle.
//
// Ports
//   CLK     in   clock, all state changes on rising edge
//   RST     in   synchronous active-high reset (priority over START)
//   START   in   request; only sampled in IDLE
//   A, B    in   WIDTH-bit unsigned minuend / subtrahend, captured on accept
//   BUSY    out  high while bit-steps are in progress (SHIFT)
//   DONE    out  one-cycle pulse when DIFF/BORROW are newly valid (FINISH)
//   DIFF    out  registered (A - B) mod 2^WIDTH
//   BORROW  out  registered final borrow, 1 iff A < B
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One full-subtractor bit-step on the current LSBs.
    logic             step_d;
    logic             step_bout;
    logic [WIDTH-1:0] res_shifted;

    always_comb begin
        step_d      = a_q[0] ^ b_q[0] ^ bin_q;
        step_bout   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
        // New difference bit enters at the MSB; after WIDTH steps the first
        // (LSB) bit has reached position 0.
        res_shifted = {step_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    cnt_d   = '0;
                    bin_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = res_shifted;
                bin_d = step_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final step: publish result on the same edge.
                    diff_d   = res_shifted;
                    borrow_d = step_bout;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign DIFF   = diff_q;
    assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH=8). Expected results are
//   queued when an operation is launched and popped by a monitor whenever
//   DONE is seen; handshake timing is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [W-1:0] A, B;
    logic         BUSY, DONE;
    logic [W-1:0] DIFF;
    logic         BORROW;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    int   done_times[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DIFF  (DIFF),
        .BORROW(BORROW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.diff   = W'(a - b);
        e.borrow = (a < b);
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every DONE pulse must match the oldest launched operation.
    always @(negedge CLK) begin
        if (!RST) chk("busy_done_overlap", {31'd0, BUSY & DONE}, 32'd0);
        if (DONE) begin
            done_cnt++;
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("diff", {24'd0, DIFF}, {24'd0, e.diff});
                chk("borrow", {31'd0, BORROW}, {31'd0, e.borrow});
            end
        end
    end

    // Launch one operation; returns cycles from the accepting edge to DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        START = 1'b1; A = a; B = b;
        exp_q.push_back(model(a, b));
        step();                       // accepting edge t0
        START = 1'b0;
        lat = 0;
        while (!DONE && lat < 40) begin
            chk("busy_during_shift", {31'd0, BUSY}, 32'd1);
            step();
            lat++;
        end
        chk("done_latency", lat, W);
        chk("busy_at_done", {31'd0, BUSY}, 32'd0);
        step();
        chk("done_one_cycle", {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int   lat;
        int   base;
        exp_t e;
        logic [W-1:0] ra, rb;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   base;
        logic [W-1:0] ra, rb;

        RST = 1'b1; START = 1'b0; A = '0; B = '0;
        step(); step();
        RST = 1'b0;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_diff", {24'd0, DIFF}, 32'd0);
        chk("rst_borrow", {31'd0, BORROW}, 32'd0);

        // Basic operation and boundaries.
        run_op(8'h3C, 8'h0F, lat);
        chk("diff_hold_3c", {24'd0, DIFF}, 32'h2D);
        run_op(8'h00, 8'h01, lat);
        run_op(8'hAA, 8'hAA, lat);
        run_op(8'h00, 8'hFF, lat);

        // START during SHIFT at step 3 must be ignored.
        base = done_cnt;
        START = 1'b1; A = 8'h50; B = 8'h20;
        exp_q.push_back(model(8'h50, 8'h20));
        step();
        START = 1'b0;
        step(); step(); step();
        START = 1'b1; A = 8'h01; B = 8'h02;
        step();
        START = 1'b0;
        repeat (15) step();
        chk("ignored_start_single_done", done_cnt - base, 1);
        chk("ignored_start_diff", {24'd0, DIFF}, 32'h30);

        // Operands wiggling mid-operation must not matter.
        base = done_cnt;
        START = 1'b1; A = 8'h96; B = 8'hC3;
        exp_q.push_back(model(8'h96, 8'hC3));
        step();
        START = 1'b0;
        repeat (12) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            A = ra; B = rb;
            step();
        end
        chk("wiggle_single_done", done_cnt - base, 1);
        chk("wiggle_diff", {24'd0, DIFF}, 32'hD3);
        chk("wiggle_borrow", {31'd0, BORROW}, 32'd1);

        // Reset at step 4 aborts with no DONE and clears outputs.
        base = done_cnt;
        START = 1'b1; A = 8'h80; B = 8'h01;
        step();
        START = 1'b0;
        step(); step(); step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_diff", {24'd0, DIFF}, 32'd0);
        chk("abort_borrow", {31'd0, BORROW}, 32'd0);
        repeat (12) step();
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_diff_later", {24'd0, DIFF}, 32'd0);
        run_op(8'h10, 8'h01, lat);

        // RST beats START on the same edge.
        base = done_cnt;
        RST = 1'b1; START = 1'b1; A = 8'h44; B = 8'h11;
        step();
        RST = 1'b0; START = 1'b0;
        chk("rst_prio_busy", {31'd0, BUSY}, 32'd0);
        repeat (12) step();
        chk("rst_prio_no_done", done_cnt - base, 0);

        // START held high: three back-to-back operations, period W+2.
        base = done_cnt;
        done_times.delete();
        START = 1'b1; A = 8'h12; B = 8'h34;
        exp_q.push_back(model(8'h12, 8'h34));
        step();
        A = 8'hF0; B = 8'h0F;
        exp_q.push_back(model(8'hF0, 8'h0F));
        repeat (W + 2) step();
        A = 8'h7F; B = 8'h80;
        exp_q.push_back(model(8'h7F, 8'h80));
        repeat (W + 2) step();
        START = 1'b0;
        lat = 0;
        while (done_cnt - base < 3 && lat < 40) begin
            step();
            lat++;
        end
        repeat (4) step();
        chk("b2b_done_count", done_cnt - base, 3);
        if (done_times.size() == 3) begin
            chk("b2b_period_1", done_times[1] - done_times[0], W + 2);
            chk("b2b_period_2", done_times[2] - done_times[1], W + 2);
        end else begin
            chk("b2b_times_recorded", done_times.size(), 3);
        end

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
